fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 FB_AW, 10, framebuffer address width (1024 bytes, 128x64 mono, 8 px per byte).
REQ-002 FB_DW, 8, framebuffer data width.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_btn  input  1  reset, asynchronous assert, active-low.
REQ-005 disp_req  input  1  display-driver read request.
REQ-006 disp_addr  input  FB_AW  display read address.
REQ-007 disp_data  output  FB_DW  read data, registered.
REQ-008 disp_valid  output  1  disp_data valid, one-cycle pulse.
REQ-009 wr0_req, wr1_req  input  1 each  writer requests, held until acked.
REQ-010 wr0_addr, wr1_addr  input  FB_AW each  write addresses, stable while req high.
REQ-011 wr0_data, wr1_data  input  FB_DW each  write data, stable while req high.
REQ-012 wr0_ack, wr1_ack  output  1 each  one-cycle pulse in the cycle the write commits.
REQ-013 clr_start  input  1  single-cycle pulse; fill whole framebuffer with clr_value.
REQ-014 clr_value  input  FB_DW  fill byte, sampled on accepted clr_start.
REQ-015 clr_busy  output  1  high while a clear is in progress.
REQ-016 clr_done  output  1  one-cycle pulse after the last clear write.

Function
REQ-017 The block SHALL own one single-port synchronous RAM of 2^FB_AW x FB_DW; at most one access per cycle.
REQ-018 Fixed priority per cycle: display read > clear write > writer writes.
REQ-019 disp_req high SHALL always be served that cycle; disp_data/disp_valid appear next cycle (latency 1), sustained throughput one read per cycle.
REQ-020 States IDLE and CLEAR; IDLE->CLEAR on clr_start, CLEAR->IDLE after writing address 2^FB_AW-1.
REQ-021 Accepting clr_start in IDLE SHALL latch clr_value, zero the clear pointer, raise clr_busy next cycle; clr_start in CLEAR is ignored.
REQ-022 In CLEAR, each cycle without disp_req SHALL write the latched value at the pointer and increment it; disp_req stalls the pointer.
REQ-023 Last clear write at 1023 SHALL pulse clr_done the following cycle and drop clr_busy the same cycle; pointer never wraps.
REQ-024 Writers SHALL receive no grant while in CLEAR (wr*_ack stays low).
REQ-025 In IDLE without disp_req, one pending writer is granted and acked that cycle.
REQ-026 Both writers pending: round-robin, the writer not granted last wins; after reset writer 0 wins first.
REQ-027 A writer SHALL never be acked twice for one request; its next request is seen no earlier than the cycle after ack.
REQ-028 Max writer wait with continuous display reads is unbounded; with disp_req low, at most 2 cycles when both pending.
REQ-029 Read and write to the same address in consecutive cycles: the read returns the value committed before the read cycle.

Reset
REQ-030 rst_btn low SHALL immediately force: state IDLE, disp_valid 0, disp_data 0, wr0_ack/wr1_ack 0, clr_busy 0, clr_done 0, pointer 0, round-robin to writer 0.
REQ-031 Reset mid-clear SHALL abort without clr_done; RAM contents are not reset.

Structure
REQ-032 FB_AW, FB_DW, FB_DEPTH and state encodings SHALL live in shared package fb_pkg.
REQ-033 The RAM SHALL be sub-module fb_ram (single-port, sync read, write-enable).

Verification
REQ-034 Writer 0 writes 0x5A to 0x010, then display reads 0x010 -> wr0_ack one pulse, disp_valid next cycle with disp_data=0x5A.
REQ-035 Both writers request simultaneously after reset (0x001<-0x11, 0x002<-0x22) -> wr0_ack cycle N, wr1_ack cycle N+1.
REQ-036 clr_start with clr_value=0xFF, no display traffic -> clr_busy 1024 cycles, clr_done one pulse, reads of 0x000 and 0x3FF return 0xFF.
REQ-037 Clear running with disp_req high 100 cycles -> completion delayed exactly 100 cycles; reads valid every cycle; writer held pending with no ack until clr_done.
REQ-038 rst_btn low at pointer 0x200 -> outputs reset immediately, no clr_done, 0x1FF holds fill value, 0x200 holds prior data.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and arbiter state encoding.
// Every framebuffer module imports this package so all of them agree on these sizes.
package fb_pkg;
    localparam int FB_AW    = 10;
    localparam int FB_DW    = 8;
    localparam int FB_DEPTH = 1 << FB_AW;

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fbState_t;
endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer RAM with a registered read port.
// Each cycle, the port performs either one read or one write.
module fb_ram
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [FB_AW-1:0] addr,
    input  logic [FB_DW-1:0] wdata,
    output logic [FB_DW-1:0] rdata
);
    logic [FB_DW-1:0] mem [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// Shares one framebuffer RAM between a display reader, a bulk clear engine and two writers.
// Access priority is: display read, then clear write, then the writers in round-robin order.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             disp_req,
    input  logic [FB_AW-1:0] disp_addr,
    output logic [FB_DW-1:0] disp_data,
    output logic             disp_valid,
    input  logic             wr0_req,
    input  logic [FB_AW-1:0] wr0_addr,
    input  logic [FB_DW-1:0] wr0_data,
    output logic             wr0_ack,
    input  logic             wr1_req,
    input  logic [FB_AW-1:0] wr1_addr,
    input  logic [FB_DW-1:0] wr1_data,
    output logic             wr1_ack,
    input  logic             clr_start,
    input  logic [FB_DW-1:0] clr_value,
    output logic             clr_busy,
    output logic             clr_done
);
    fbState_t         stateReg, stateNext;
    logic [FB_AW-1:0] ptrReg, ptrNext;
    logic [FB_DW-1:0] fillReg, fillNext;
    logic             prefReg, prefNext;   // writer that wins when both are pending
    logic             dispValidReg;
    logic             clrDoneReg, clrDoneNext;

    logic             grant0, grant1, clearWrite;
    logic             ramEn, ramWe;
    logic [FB_AW-1:0] ramAddr;
    logic [FB_DW-1:0] ramWdata, ramRdata;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            stateReg     <= IDLE;
            ptrReg       <= '0;
            fillReg      <= '0;
            prefReg      <= 1'b0;
            dispValidReg <= 1'b0;
            clrDoneReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            ptrReg       <= ptrNext;
            fillReg      <= fillNext;
            prefReg      <= prefNext;
            dispValidReg <= disp_req;
            clrDoneReg   <= clrDoneNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        ptrNext     = ptrReg;
        fillNext    = fillReg;
        prefNext    = prefReg;
        clrDoneNext = 1'b0;
        case (stateReg)
            IDLE: begin
                if (clr_start) begin
                    stateNext = CLEAR;
                    ptrNext   = '0;
                    fillNext  = clr_value;
                end
                if (grant0) begin
                    prefNext = 1'b1;
                end else if (grant1) begin
                    prefNext = 1'b0;
                end
            end
            CLEAR: begin
                if (clearWrite) begin
                    if (ptrReg == LAST_ADDR) begin
                        stateNext   = IDLE;
                        clrDoneNext = 1'b1;
                    end else begin
                        ptrNext = ptrReg + FB_AW'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        clearWrite = 1'b0;
        ramEn      = 1'b0;
        ramWe      = 1'b0;
        ramAddr    = disp_addr;
        ramWdata   = fillReg;
        if (disp_req) begin
            ramEn = 1'b1;
        end else if (stateReg == CLEAR) begin
            clearWrite = 1'b1;
            ramEn      = 1'b1;
            ramWe      = 1'b1;
            ramAddr    = ptrReg;
        end else if (wr0_req && (!wr1_req || !prefReg)) begin
            grant0   = 1'b1;
            ramEn    = 1'b1;
            ramWe    = 1'b1;
            ramAddr  = wr0_addr;
            ramWdata = wr0_data;
        end else if (wr1_req) begin
            grant1   = 1'b1;
            ramEn    = 1'b1;
            ramWe    = 1'b1;
            ramAddr  = wr1_addr;
            ramWdata = wr1_data;
        end
    end

    // Acks and RAM enable are qualified by reset so nothing commits or is acknowledged while it is held.
    assign wr0_ack    = grant0 & rst_btn;
    assign wr1_ack    = grant1 & rst_btn;
    assign clr_busy   = (stateReg == CLEAR);
    assign clr_done   = clrDoneReg;
    assign disp_valid = dispValidReg;
    assign disp_data  = dispValidReg ? ramRdata : '0;

    fb_ram uRam (
        .clk   (clk),
        .en    (ramEn & rst_btn),
        .we    (ramWe),
        .addr  (ramAddr),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );
endmodule

// File: tb/tb_fb_arbiter.sv
// Randomised bench for fb_arbiter: a behavioural framebuffer model is checked every cycle,
// and directed scenarios add literal expectations.
module tb_fb_arbiter;
    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic       disp_req = 1'b0;
    logic [9:0] disp_addr = '0;
    logic [7:0] disp_data;
    logic       disp_valid;
    logic       wr0_req = 1'b0, wr1_req = 1'b0;
    logic [9:0] wr0_addr = '0, wr1_addr = '0;
    logic [7:0] wr0_data = '0, wr1_data = '0;
    logic       wr0_ack, wr1_ack;
    logic       clr_start = 1'b0;
    logic [7:0] clr_value = '0;
    logic       clr_busy, clr_done;

    int nChecks = 0;
    int nFails  = 0;

    fb_arbiter dut (
        .clk(clk), .rst_btn(rst_btn),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: framebuffer contents, remaining clear writes, last granted writer.
    logic [7:0] modelMem [1024];
    bit         known [1024];
    int         clearLeft = 0;
    logic [7:0] fillVal = '0;
    int         lastWinner = 1;
    bit         expValid = 0, expKnown = 0, expDone = 0;
    logic [7:0] expData = '0;
    bit         mIdle, mG0, mG1;

    always @(negedge clk) begin
        if (!rst_btn) begin
            check("rst_valid", disp_valid, 0);
            check("rst_data", disp_data, 0);
            check("rst_ack0", wr0_ack, 0);
            check("rst_ack1", wr1_ack, 0);
            check("rst_busy", clr_busy, 0);
            check("rst_done", clr_done, 0);
            clearLeft = 0; lastWinner = 1; expValid = 0; expDone = 0;
        end else begin
            mIdle = (clearLeft == 0);
            mG0 = 0; mG1 = 0;
            if (!disp_req && mIdle) begin
                if (wr0_req && wr1_req) begin
                    mG0 = (lastWinner == 1);
                    mG1 = (lastWinner == 0);
                end else begin
                    mG0 = wr0_req;
                    mG1 = wr1_req;
                end
            end
            check("ack0", wr0_ack, mG0);
            check("ack1", wr1_ack, mG1);
            check("valid", disp_valid, expValid);
            if (expValid && expKnown) check("data", disp_data, expData);
            check("busy", clr_busy, !mIdle);
            check("done", clr_done, expDone);
            expDone = 0;
            expValid = disp_req;
            if (disp_req) begin
                expKnown = known[disp_addr];
                expData  = modelMem[disp_addr];
            end else if (!mIdle) begin
                modelMem[1024 - clearLeft] = fillVal;
                known[1024 - clearLeft] = 1;
                clearLeft--;
                if (clearLeft == 0) expDone = 1;
            end else if (mG0) begin
                modelMem[wr0_addr] = wr0_data; known[wr0_addr] = 1; lastWinner = 0;
            end else if (mG1) begin
                modelMem[wr1_addr] = wr1_data; known[wr1_addr] = 1; lastWinner = 1;
            end
            if (mIdle && clr_start) begin
                clearLeft = 1024;
                fillVal = clr_value;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input logic [9:0] addr, input logic [7:0] exp, input string name);
        disp_req = 1; disp_addr = addr;
        nextCycle();
        disp_req = 0;
        @(negedge clk);
        check({name, "_valid"}, disp_valid, 1);
        check(name, disp_data, exp);
        nextCycle();
    endtask

    task automatic doWrite(input int w, input logic [9:0] addr, input logic [7:0] data);
        bit got = 0;
        if (w == 0) begin wr0_req = 1; wr0_addr = addr; wr0_data = data; end
        else        begin wr1_req = 1; wr1_addr = addr; wr1_data = data; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (w == 0) ? wr0_ack : wr1_ack;
            nextCycle();
        end
        wr0_req = 0; wr1_req = 0;
        check("write_acked", got, 1);
    endtask

    int  busyCnt, doneCnt, validCnt, ackBusy;
    bit  ackAtDone, a0, a1;

    initial begin
        repeat (3) nextCycle();
        @(negedge clk);
        check("reset_data", disp_data, 0);
        check("reset_busy", clr_busy, 0);
        nextCycle();
        rst_btn = 1;

        // Simultaneous writers straight after reset: writer 0 first, then writer 1.
        wr0_req = 1; wr0_addr = 10'h001; wr0_data = 8'h11;
        wr1_req = 1; wr1_addr = 10'h002; wr1_data = 8'h22;
        @(negedge clk);
        check("rr_first_ack0", wr0_ack, 1);
        check("rr_first_ack1", wr1_ack, 0);
        nextCycle();
        wr0_req = 0;
        @(negedge clk);
        check("rr_second_ack1", wr1_ack, 1);
        check("rr_second_ack0", wr0_ack, 0);
        nextCycle();
        wr1_req = 0;

        // Single write then a read-back of the same address.
        wr0_req = 1; wr0_addr = 10'h010; wr0_data = 8'h5A;
        @(negedge clk);
        check("w5a_ack", wr0_ack, 1);
        nextCycle();
        wr0_req = 0;
        disp_req = 1; disp_addr = 10'h010;
        @(negedge clk);
        check("w5a_ack_once", wr0_ack, 0);
        nextCycle();
        disp_req = 0;
        @(negedge clk);
        check("r5a_valid", disp_valid, 1);
        check("r5a_data", disp_data, 8'h5A);
        nextCycle();
        readCheck(10'h001, 8'h11, "r11");
        readCheck(10'h002, 8'h22, "r22");

        // Unobstructed clear with 0xFF.
        clr_value = 8'hFF; clr_start = 1;
        nextCycle();
        clr_start = 0;
        busyCnt = 0; doneCnt = 0;
        for (int i = 0; i < 3000 && doneCnt == 0; i++) begin
            @(negedge clk);
            if (clr_busy) busyCnt++;
            if (clr_done) doneCnt++;
            nextCycle();
        end
        check("clr_busy_cycles", busyCnt, 1024);
        check("clr_done_seen", doneCnt, 1);
        @(negedge clk);
        check("clr_done_pulse", clr_done, 0);
        nextCycle();
        readCheck(10'h000, 8'hFF, "clr_r000");
        readCheck(10'h3FF, 8'hFF, "clr_r3ff");

        // Clear stalled by 100 display reads, with writer 1 pending throughout.
        clr_value = 8'h3C; clr_start = 1;
        nextCycle();
        clr_start = 0;
        wr1_req = 1; wr1_addr = 10'h055; wr1_data = 8'h77;
        busyCnt = 0; doneCnt = 0; validCnt = 0; ackBusy = 0; ackAtDone = 0;
        for (int k = 0; k < 3000 && doneCnt == 0; k++) begin
            disp_req = (k < 100);
            disp_addr = 10'($urandom_range(0, 1023));
            @(negedge clk);
            if (clr_busy) busyCnt++;
            if (clr_busy && wr1_ack) ackBusy++;
            if (disp_valid) validCnt++;
            if (clr_done) begin doneCnt++; ackAtDone = wr1_ack; end
            nextCycle();
        end
        disp_req = 0; wr1_req = 0;
        check("stall_busy_cycles", busyCnt, 1124);
        check("stall_reads_valid", validCnt, 100);
        check("stall_no_ack", ackBusy, 0);
        check("stall_ack_at_done", ackAtDone, 1);
        readCheck(10'h055, 8'h77, "stall_wr_data");
        readCheck(10'h100, 8'h3C, "stall_fill");

        // Reset while the clear pointer sits at 0x200.
        doWrite(0, 10'h1FF, 8'h12);
        doWrite(1, 10'h200, 8'h34);
        clr_value = 8'hAB; clr_start = 1;
        nextCycle();
        clr_start = 0;
        repeat (10'h200) nextCycle();
        #2;
        rst_btn = 0;
        #1;
        check("abort_busy", clr_busy, 0);
        check("abort_done", clr_done, 0);
        check("abort_valid", disp_valid, 0);
        check("abort_data", disp_data, 0);
        nextCycle();
        rst_btn = 1;
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clr_done || clr_busy) doneCnt++;
            nextCycle();
        end
        check("abort_quiet", doneCnt, 0);
        readCheck(10'h1FF, 8'hAB, "abort_r1ff");
        readCheck(10'h200, 8'h34, "abort_r200");

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            a0 = wr0_ack; a1 = wr1_ack;
            nextCycle();
            if (a0) wr0_req = 0;
            if (a1) wr1_req = 0;
            if (!wr0_req && $urandom_range(0, 2) == 0) begin
                wr0_req = 1; wr0_addr = 10'($urandom_range(0, 15)); wr0_data = 8'($urandom);
            end
            if (!wr1_req && $urandom_range(0, 2) == 0) begin
                wr1_req = 1; wr1_addr = 10'($urandom_range(0, 15)); wr1_data = 8'($urandom);
            end
            disp_req  = ($urandom_range(0, 3) == 0);
            disp_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                    : 10'($urandom_range(0, 15));
            clr_start = (c == 1000) || ($urandom_range(0, 1499) == 0);
            clr_value = 8'($urandom);
        end
        wr0_req = 0; wr1_req = 0; disp_req = 0; clr_start = 0;
        repeat (2) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
